csr_rmw_ctrl: RTL and testbench
===============================

# csr_rmw_ctrl

Read-modify-write controller sitting directly upstream of the CSR field registers. It accepts one CSR instruction at a time from the execute stage (CSRRW/CSRRS/CSRRC semantics) over a valid/ready handshake, then reads the addressed CSR and checks legality. For a legal write it drives a single-cycle `en`/`set`/`clear` pulse into the field bank, and it returns the pre-write value over a valid/ready response channel.

## Interface
- `XLEN`, default 32: CSR data width.
- `ADDR_W`, default 12: CSR address width.

- `clk_i` input 1: clock. The block has one clock.
- `rst_i` input 1: reset, synchronous and active-high.
- `req_valid_i` input 1: request valid.
- `req_ready_o` output 1: request ready.
- `req_op_i` input 2: operation. 01 = RW, 10 = RS, 11 = RC, 00 = reserved.
- `req_addr_i` input ADDR_W: CSR address.
- `req_wdata_i` input XLEN: write operand (rs1 value or zimm).
- `req_nowrite_i` input 1: suppress the write (RS/RC with rs1 = x0 or zimm = 0).
- `rsp_valid_o` output 1: response valid.
- `rsp_ready_i` input 1: response ready.
- `rsp_rdata_o` output XLEN: old CSR value.
- `rsp_illegal_o` output 1: illegal-instruction flag.
- `csr_addr_o` output ADDR_W: address presented to the field bank.
- `csr_rdata_i` input XLEN: current value of `csr_addr_o`, combinational from the bank.
- `csr_exists_i` input 1: `csr_addr_o` is implemented.
- `csr_en_o` output 1: write-enable pulse to the fields.
- `csr_set_o` output XLEN: bits to set.
- `csr_clear_o` output XLEN: bits to clear.

## Operation
The field bank computes `new = (old & ~clear) | set` when `en` is high.

FSM states: IDLE, READ, WRITE, RESP.

- **IDLE**
  - `req_ready_o` = 1.
  - On `req_valid_i & req_ready_o`: latch op, addr, wdata and nowrite, then go to READ.
- **READ**
  - `csr_addr_o` = latched address.
  - Capture `csr_rdata_i` into `old_q`.
  - `illegal` = `!csr_exists_i` | (op == 00) | (write intended & addr[11:10] == 2'b11).
  - "Write intended" = op == RW, or `!nowrite`. RW always writes; `nowrite` only affects RS/RC.
  - Next state:
    - illegal → RESP, with `old_q` forced to 0 and the illegal flag set.
    - RS/RC with `nowrite` → RESP.
    - otherwise → WRITE.
- **WRITE**: drive `csr_en_o` = 1 for exactly one cycle, then go to RESP.
  - RW: set = wdata, clear = all ones.
  - RS: set = wdata, clear = 0.
  - RC: set = 0, clear = wdata.
- **RESP**
  - `rsp_valid_o` = 1, `rsp_rdata_o` = `old_q`, `rsp_illegal_o` = illegal flag.
  - All three are held stable until `rsp_ready_i`, then go to IDLE.
- A CSR never receives an `en` pulse for an illegal or suppressed access.
- `csr_set_o` and `csr_clear_o` are 0 whenever `csr_en_o` = 0.

## Timing
- **Reset values**
  - State = IDLE.
  - `req_ready_o` = 0 while `rst_i` is high, 1 in the first cycle after.
  - `rsp_valid_o`, `rsp_illegal_o`, `csr_en_o` = 0.
  - `rsp_rdata_o`, `csr_set_o`, `csr_clear_o`, `csr_addr_o` = 0.
- **Latency**, with the request accepted at the edge ending cycle T:
  - READ runs in T+1.
  - WRITE runs in T+2, and the field value updates at the end of T+2.
  - `rsp_valid_o` is high from T+3 for a write, or from T+2 for a suppressed or illegal access.
- **Throughput**
  - At most one access is in flight.
  - The next request can be accepted in the cycle after the response handshake.
  - Minimum spacing is 4 cycles for writes and 3 for reads.
- **Handshakes**
  - The requester holds the request inputs stable until accepted. Inputs are sampled only at acceptance.
  - Response backpressure of any length is tolerated. Outputs do not change while `rsp_valid_o & !rsp_ready_i`.
- `csr_addr_o` is registered and holds the latched address from READ until the next acceptance.
- **Reset mid-operation**
  - `rst_i` in any state aborts the access in that same cycle.
  - `csr_en_o` is gated low while `rst_i` is high, so a WRITE aborted by reset leaves the field unchanged.
  - No response is produced for the aborted access.
- `req_valid_i` seen during `rst_i` is ignored.

## Test plan
- **RW**: field = 0x0000_00F0, RW wdata 0x1234_5678 → one `en` pulse with set 0x1234_5678, clear 0xFFFF_FFFF; rsp rdata 0x0000_00F0, illegal 0; field becomes 0x1234_5678; rsp_valid at T+3.
- **RS then RC**: field = 0x0F, RS 0xF0 → rdata 0x0F, field 0xFF. Then RC 0x3C → rdata 0xFF, field 0xC3; clear = 0x3C, set = 0.
- **RS with nowrite=1**: nowrite=1, wdata 0xFFFF_FFFF → no `en` pulse, rdata = current value, rsp_valid at T+2.
- **Illegal accesses**
  - op 00 → illegal 1, rdata 0, no `en`.
  - `csr_exists_i` = 0 → illegal 1, rdata 0, no `en`.
  - RW to 0xC00 → illegal 1, rdata 0, no `en`.
  - RS to 0xC00 with nowrite → legal, returns value.
- **Backpressure**: hold `rsp_ready_i` low for 5 cycles → rsp outputs stable, `req_ready_o` = 0 throughout; release → IDLE next cycle, and a queued request is accepted there.
- **Reset during WRITE**: assert `rst_i` in the WRITE cycle → `csr_en_o` = 0, field unchanged, no response; the next request completes normally.

Source files
------------

// File: rtl/csr_rmw_ctrl.sv
// Read-modify-write sequencer for CSR instructions: reads the addressed CSR, checks
// legality, emits one en/set/clear pulse for legal writes and returns the old value.
module csr_rmw_ctrl #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 12
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [1:0]        req_op_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [XLEN-1:0]   req_wdata_i,
   input  logic              req_nowrite_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [XLEN-1:0]   rsp_rdata_o,
   output logic              rsp_illegal_o,
   output logic [ADDR_W-1:0] csr_addr_o,
   input  logic [XLEN-1:0]   csr_rdata_i,
   input  logic              csr_exists_i,
   output logic              csr_en_o,
   output logic [XLEN-1:0]   csr_set_o,
   output logic [XLEN-1:0]   csr_clear_o
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both
   // high; the sender holds valid and payload stable until then, and the receiver
   // may raise or drop ready freely.

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   localparam logic [1:0] OP_RES = 2'b00;
   localparam logic [1:0] OP_RW  = 2'b01;
   localparam logic [1:0] OP_RS  = 2'b10;
   localparam logic [1:0] OP_RC  = 2'b11;

   state_e            state_q;
   logic [1:0]        op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [XLEN-1:0]   wdata_q;
   logic              nowrite_q;
   logic              ready_q;
   logic              rsp_valid_q;
   logic              rsp_illegal_q;
   logic [XLEN-1:0]   old_q;
   logic              en_q;
   logic [XLEN-1:0]   set_q;
   logic [XLEN-1:0]   clear_q;

   logic              write_intended;
   logic              rd_illegal;

   // RW always writes; nowrite only suppresses RS/RC.
   always_comb begin
      write_intended = (op_q == OP_RW) || !nowrite_q;
      rd_illegal     = !csr_exists_i
                    || (op_q == OP_RES)
                    || (write_intended && (addr_q[ADDR_W-1 -: 2] == 2'b11));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= ST_IDLE;
         ready_q       <= 1'b1;
         op_q          <= OP_RES;
         addr_q        <= '0;
         wdata_q       <= '0;
         nowrite_q     <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_illegal_q <= 1'b0;
         old_q         <= '0;
         en_q          <= 1'b0;
         set_q         <= '0;
         clear_q       <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid_i && ready_q) begin
                  op_q      <= req_op_i;
                  addr_q    <= req_addr_i;
                  wdata_q   <= req_wdata_i;
                  nowrite_q <= req_nowrite_i;
                  ready_q   <= 1'b0;
                  state_q   <= ST_READ;
               end
            end
            ST_READ: begin
               if (rd_illegal) begin
                  old_q         <= '0;
                  rsp_illegal_q <= 1'b1;
                  rsp_valid_q   <= 1'b1;
                  state_q       <= ST_RESP;
               end else if (!write_intended) begin
                  old_q         <= csr_rdata_i;
                  rsp_illegal_q <= 1'b0;
                  rsp_valid_q   <= 1'b1;
                  state_q       <= ST_RESP;
               end else begin
                  old_q         <= csr_rdata_i;
                  rsp_illegal_q <= 1'b0;
                  en_q          <= 1'b1;
                  state_q       <= ST_WRITE;
                  case (op_q)
                     OP_RW: begin
                        set_q   <= wdata_q;
                        clear_q <= '1;
                     end
                     OP_RS: begin
                        set_q   <= wdata_q;
                        clear_q <= '0;
                     end
                     OP_RC: begin
                        set_q   <= '0;
                        clear_q <= wdata_q;
                     end
                     default: begin
                        set_q   <= '0;
                        clear_q <= '0;
                     end
                  endcase
               end
            end
            ST_WRITE: begin
               en_q        <= 1'b0;
               set_q       <= '0;
               clear_q     <= '0;
               rsp_valid_q <= 1'b1;
               state_q     <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_q <= 1'b0;
                  ready_q     <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               ready_q <= 1'b1;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Reset aborts in the cycle it is seen, so the pulse and handshakes are masked by it.
   assign req_ready_o   = ready_q & ~rst_i;
   assign rsp_valid_o   = rsp_valid_q & ~rst_i;
   assign rsp_rdata_o   = old_q;
   assign rsp_illegal_o = rsp_illegal_q;
   assign csr_addr_o    = addr_q;
   assign csr_en_o      = en_q & ~rst_i;
   assign csr_set_o     = rst_i ? '0 : set_q;
   assign csr_clear_o   = rst_i ? '0 : clear_q;

endmodule

// File: tb/tb_csr_rmw_ctrl.sv
// Bench for csr_rmw_ctrl: a field register driven by the en/set/clear pulses,
// a vector table, randomised accesses and hand-built backpressure/reset sequences.
module tb_csr_rmw_ctrl;

   localparam int XLEN   = 32;
   localparam int ADDR_W = 12;

   localparam logic [1:0] OP_RES = 2'b00;
   localparam logic [1:0] OP_RW  = 2'b01;
   localparam logic [1:0] OP_RS  = 2'b10;
   localparam logic [1:0] OP_RC  = 2'b11;

   typedef struct {
      logic [1:0]        op;
      logic [ADDR_W-1:0] addr;
      logic [XLEN-1:0]   wdata;
      logic              nowrite;
      logic              exists;
      logic [XLEN-1:0]   init;
      logic [XLEN-1:0]   exp_rdata;
      logic              exp_ill;
      logic [XLEN-1:0]   exp_field;
      int                exp_en;
      logic [XLEN-1:0]   exp_set;
      logic [XLEN-1:0]   exp_clear;
      int                exp_lat;
   } vec_t;

   logic              clk;
   logic              rst;
   logic              req_valid;
   logic              req_ready_o;
   logic [1:0]        req_op;
   logic [ADDR_W-1:0] req_addr;
   logic [XLEN-1:0]   req_wdata;
   logic              req_nowrite;
   logic              rsp_valid_o;
   logic              rsp_ready;
   logic [XLEN-1:0]   rsp_rdata_o;
   logic              rsp_illegal_o;
   logic [ADDR_W-1:0] csr_addr_o;
   logic [XLEN-1:0]   csr_rdata;
   logic              csr_exists;
   logic              csr_en_o;
   logic [XLEN-1:0]   csr_set_o;
   logic [XLEN-1:0]   csr_clear_o;

   logic [XLEN-1:0]   field;
   logic              load_en;
   logic [XLEN-1:0]   load_val;
   logic              exists_drv;

   int                cyc = 0;
   int                checks = 0;
   int                errors = 0;
   int                en_total = 0;
   int                bad_gate = 0;
   int                first_valid_cyc = 0;
   logic              prev_valid = 1'b0;
   logic [XLEN-1:0]   last_set = '0;
   logic [XLEN-1:0]   last_clear = '0;
   logic [XLEN:0]     exp_q[$];
   logic [XLEN:0]     act_q[$];
   vec_t              vecs[13];

   csr_rmw_ctrl #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .req_valid_i   (req_valid),
      .req_ready_o   (req_ready_o),
      .req_op_i      (req_op),
      .req_addr_i    (req_addr),
      .req_wdata_i   (req_wdata),
      .req_nowrite_i (req_nowrite),
      .rsp_valid_o   (rsp_valid_o),
      .rsp_ready_i   (rsp_ready),
      .rsp_rdata_o   (rsp_rdata_o),
      .rsp_illegal_o (rsp_illegal_o),
      .csr_addr_o    (csr_addr_o),
      .csr_rdata_i   (csr_rdata),
      .csr_exists_i  (csr_exists),
      .csr_en_o      (csr_en_o),
      .csr_set_o     (csr_set_o),
      .csr_clear_o   (csr_clear_o)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // field bank
   assign csr_rdata  = field;
   assign csr_exists = exists_drv;
   always @(posedge clk) begin
      if (load_en) field <= load_val;
      else if (csr_en_o) field <= (field & ~csr_clear_o) | csr_set_o;
   end

   // output monitor
   always @(negedge clk) begin
      if (rsp_valid_o && rsp_ready) act_q.push_back({rsp_illegal_o, rsp_rdata_o});
      if (rsp_valid_o && !prev_valid) first_valid_cyc <= cyc;
      prev_valid <= rsp_valid_o;
      if (csr_en_o) begin
         en_total   <= en_total + 1;
         last_set   <= csr_set_o;
         last_clear <= csr_clear_o;
      end else if (csr_set_o != '0 || csr_clear_o != '0) begin
         bad_gate <= bad_gate + 1;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [XLEN:0] act, input logic [XLEN:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out", name);
   endtask

   // driver tasks
   task automatic load_field(input logic [XLEN-1:0] val, input logic ex);
      @(posedge clk); #1;
      load_en    = 1'b1;
      load_val   = val;
      exists_drv = ex;
      @(posedge clk); #1;
      load_en = 1'b0;
   endtask

   task automatic do_req(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                         input logic [XLEN-1:0] wdata, input logic nw,
                         output int t_acc, output bit ok);
      ok    = 1'b0;
      t_acc = 0;
      @(posedge clk); #1;
      req_valid   = 1'b1;
      req_op      = op;
      req_addr    = addr;
      req_wdata   = wdata;
      req_nowrite = nw;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (req_ready_o) begin
            t_acc = cyc;
            @(posedge clk); #1;
            req_valid = 1'b0;
            ok = 1'b1;
            break;
         end
      end
      if (!ok) req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk); #1;
         if (act_q.size() != 0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic run_vec(input string tag, input vec_t v);
      int t_acc;
      int en0;
      bit ok;
      logic [XLEN:0] got;
      logic [XLEN:0] want;
      load_field(v.init, v.exists);
      en0 = en_total;
      exp_q.push_back({v.exp_ill, v.exp_rdata});
      do_req(v.op, v.addr, v.wdata, v.nowrite, t_acc, ok);
      if (!ok) begin
         void'(exp_q.pop_back());
         fail_now({tag, "_accept"});
         return;
      end
      wait_rsp(ok);
      if (!ok) begin
         void'(exp_q.pop_back());
         fail_now({tag, "_rsp"});
         return;
      end
      got  = act_q.pop_front();
      want = exp_q.pop_front();
      chk({tag, "_rsp"}, got, want);
      chk_int({tag, "_latency"}, first_valid_cyc - t_acc, v.exp_lat);
      chk_int({tag, "_en_count"}, en_total - en0, v.exp_en);
      if (v.exp_en != 0) begin
         chk({tag, "_set"}, {1'b0, last_set}, {1'b0, v.exp_set});
         chk({tag, "_clear"}, {1'b0, last_clear}, {1'b0, v.exp_clear});
      end
      chk({tag, "_field"}, {1'b0, field}, {1'b0, v.exp_field});
   endtask

   function automatic vec_t model(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                                  input logic [XLEN-1:0] wd, input logic nw,
                                  input logic ex, input logic [XLEN-1:0] init);
      vec_t v;
      logic wi;
      logic ill;
      v.op = op; v.addr = addr; v.wdata = wd; v.nowrite = nw; v.exists = ex; v.init = init;
      wi  = (op == OP_RW) || !nw;
      ill = !ex || (op == OP_RES) || (wi && addr[11:10] == 2'b11);
      v.exp_ill   = ill;
      v.exp_rdata = ill ? '0 : init;
      v.exp_field = init;
      v.exp_en    = 0;
      v.exp_set   = '0;
      v.exp_clear = '0;
      v.exp_lat   = 2;
      if (!ill && wi) begin
         v.exp_en  = 1;
         v.exp_lat = 3;
         case (op)
            OP_RW:   begin v.exp_set = wd; v.exp_clear = '1; v.exp_field = wd; end
            OP_RS:   begin v.exp_set = wd; v.exp_field = init | wd; end
            default: begin v.exp_clear = wd; v.exp_field = init & ~wd; end
         endcase
      end
      return v;
   endfunction

   initial begin
      int  t;
      int  t2;
      int  en0;
      bit  ok;
      bit  seen;
      logic [XLEN:0] got;
      logic [XLEN:0] want;
      logic [ADDR_W-1:0] addr_pick[4];

      //         op      addr     wdata          nw    ex    init           rdata          ill   field          en set            clear          lat
      vecs[0]  = '{OP_RW,  12'h300, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_00F0, 32'h0000_00F0, 1'b0, 32'h1234_5678, 1, 32'h1234_5678, 32'hFFFF_FFFF, 3};
      vecs[1]  = '{OP_RS,  12'h300, 32'h0000_00F0, 1'b0, 1'b1, 32'h0000_000F, 32'h0000_000F, 1'b0, 32'h0000_00FF, 1, 32'h0000_00F0, 32'h0000_0000, 3};
      vecs[2]  = '{OP_RC,  12'h300, 32'h0000_003C, 1'b0, 1'b1, 32'h0000_00FF, 32'h0000_00FF, 1'b0, 32'h0000_00C3, 1, 32'h0000_0000, 32'h0000_003C, 3};
      vecs[3]  = '{OP_RS,  12'h300, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_A5A5, 32'h0000_A5A5, 1'b0, 32'h0000_A5A5, 0, 32'h0,         32'h0,         2};
      vecs[4]  = '{OP_RES, 12'h300, 32'h0000_1234, 1'b0, 1'b1, 32'h0000_0055, 32'h0000_0000, 1'b1, 32'h0000_0055, 0, 32'h0,         32'h0,         2};
      vecs[5]  = '{OP_RW,  12'h300, 32'h0000_FFFF, 1'b0, 1'b0, 32'h0000_0077, 32'h0000_0000, 1'b1, 32'h0000_0077, 0, 32'h0,         32'h0,         2};
      vecs[6]  = '{OP_RW,  12'hC00, 32'h0000_FFFF, 1'b0, 1'b1, 32'h0000_0088, 32'h0000_0000, 1'b1, 32'h0000_0088, 0, 32'h0,         32'h0,         2};
      vecs[7]  = '{OP_RS,  12'hC00, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_0099, 32'h0000_0099, 1'b0, 32'h0000_0099, 0, 32'h0,         32'h0,         2};
      vecs[8]  = '{OP_RC,  12'h300, 32'h0000_00FF, 1'b1, 1'b1, 32'h0000_F0F0, 32'h0000_F0F0, 1'b0, 32'h0000_F0F0, 0, 32'h0,         32'h0,         2};
      vecs[9]  = '{OP_RW,  12'h340, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h0000_0001, 32'h0000_0001, 1'b0, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 3};
      vecs[10] = '{OP_RS,  12'hC00, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0002, 32'h0000_0000, 1'b1, 32'h0000_0002, 0, 32'h0,         32'h0,         2};
      vecs[11] = '{OP_RC,  12'h7C0, 32'h0000_000F, 1'b0, 1'b1, 32'h0000_00FF, 32'h0000_00FF, 1'b0, 32'h0000_00F0, 1, 32'h0,         32'h0000_000F, 3};
      vecs[12] = '{OP_RS,  12'h300, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0005, 32'h0000_0000, 1'b1, 32'h0000_0005, 0, 32'h0,         32'h0,         2};

      addr_pick[0] = 12'h300;
      addr_pick[1] = 12'hC00;
      addr_pick[2] = 12'h7C0;
      addr_pick[3] = 12'hF14;

      rst         = 1'b1;
      req_valid   = 1'b1;
      req_op      = OP_RW;
      req_addr    = 12'h123;
      req_wdata   = 32'hFFFF_FFFF;
      req_nowrite = 1'b0;
      rsp_ready   = 1'b1;
      load_en     = 1'b0;
      load_val    = '0;
      exists_drv  = 1'b1;
      field       = '0;

      // reset state, with a request presented during reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", {32'b0, req_ready_o}, 33'd0);
      chk("rst_rsp_valid", {32'b0, rsp_valid_o}, 33'd0);
      chk("rst_rsp_illegal", {32'b0, rsp_illegal_o}, 33'd0);
      chk("rst_rsp_rdata", {1'b0, rsp_rdata_o}, 33'd0);
      chk("rst_csr_en", {32'b0, csr_en_o}, 33'd0);
      chk("rst_csr_set", {1'b0, csr_set_o}, 33'd0);
      chk("rst_csr_clear", {1'b0, csr_clear_o}, 33'd0);
      chk("rst_csr_addr", {21'b0, csr_addr_o}, 33'd0);
      @(posedge clk); #1;
      rst       = 1'b0;
      req_valid = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", {32'b0, req_ready_o}, 33'd1);
      chk("post_rst_addr", {21'b0, csr_addr_o}, 33'd0);
      chk_int("post_rst_no_en", en_total, 0);

      // vector table
      for (int i = 0; i < 13; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

      // randomised accesses
      for (int i = 0; i < 24; i++) begin
         vec_t rv;
         rv = model(2'($urandom_range(0, 3)), addr_pick[$urandom_range(0, 3)], $urandom(),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), $urandom());
         run_vec($sformatf("rand%0d", i), rv);
      end

      // response backpressure with a queued request
      load_field(32'h0000_0003, 1'b1);
      rsp_ready = 1'b0;
      exp_q.push_back({1'b0, 32'h0000_0003});
      do_req(OP_RW, 12'h300, 32'h0000_00AB, 1'b0, t, ok);
      if (!ok) fail_now("bp_accept");
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rsp_valid_o) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) fail_now("bp_valid");
      else chk_int("bp_latency", cyc - t, 3);
      @(posedge clk); #1;
      req_valid   = 1'b1;
      req_op      = OP_RS;
      req_addr    = 12'h300;
      req_wdata   = 32'h0;
      req_nowrite = 1'b1;
      exp_q.push_back({1'b0, 32'h0000_00AB});
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("bp_hold_valid%0d", i), {32'b0, rsp_valid_o}, 33'd1);
         chk($sformatf("bp_hold_rdata%0d", i), {1'b0, rsp_rdata_o}, {1'b0, 32'h0000_0003});
         chk($sformatf("bp_hold_illegal%0d", i), {32'b0, rsp_illegal_o}, 33'd0);
         chk($sformatf("bp_hold_ready%0d", i), {32'b0, req_ready_o}, 33'd0);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk); #1;
      if (act_q.size() != 0) begin
         got  = act_q.pop_front();
         want = exp_q.pop_front();
         chk("bp_rsp1", got, want);
      end else begin
         fail_now("bp_rsp1");
      end
      @(negedge clk);
      chk("bp_idle_ready", {32'b0, req_ready_o}, 33'd1);
      chk("bp_idle_valid", {32'b0, rsp_valid_o}, 33'd0);
      t2 = cyc;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("bp_q_accepted", {32'b0, req_ready_o}, 33'd0);
      chk("bp_q_addr", {21'b0, csr_addr_o}, {21'b0, 12'h300});
      wait_rsp(ok);
      if (ok) begin
         got  = act_q.pop_front();
         want = exp_q.pop_front();
         chk("bp_rsp2", got, want);
         chk_int("bp_rsp2_latency", first_valid_cyc - t2, 2);
      end else begin
         void'(exp_q.pop_front());
         fail_now("bp_rsp2");
      end

      // reset asserted in the WRITE cycle
      load_field(32'h0000_0011, 1'b1);
      en0 = en_total;
      do_req(OP_RW, 12'h300, 32'h0000_0099, 1'b0, t, ok);
      if (!ok) fail_now("rstw_accept");
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("rstw_en", {32'b0, csr_en_o}, 33'd0);
      chk("rstw_set", {1'b0, csr_set_o}, 33'd0);
      chk("rstw_rsp_valid", {32'b0, rsp_valid_o}, 33'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("rstw_field", {1'b0, field}, {1'b0, 32'h0000_0011});
      chk_int("rstw_no_en", en_total - en0, 0);
      chk_int("rstw_no_rsp", act_q.size(), 0);
      chk("rstw_ready", {32'b0, req_ready_o}, 33'd1);
      run_vec("post_rstw", vecs[0]);

      @(negedge clk);
      chk_int("set_clear_gated", bad_gate, 0);
      chk_int("exp_q_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
